// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   Control block for a 1 Hz mod-60 stopwatch. Two raw push buttons are
//   synchronized, debounced and turned into single-cycle press events. Those
//   events drive a four-state FSM (IDLE / RUN / LAPF / STOP). The FSM gates the
//   prescaler tick into the counter, clears the counter while idle, and can
//   freeze the display on a captured lap value.
//
// Parameters
//   DB_MAX      debounce stability window in clk_i cycles (2 .. 2^20-1)
//
// Ports
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous active-low reset
//   tick_i      one-cycle 1 Hz enable from the prescaler
//   btn_ss_i    raw start/stop button, active high, asynchronous
//   btn_lap_i   raw lap/clear button, active high, asynchronous
//   cnt10_i     live ones digit from the mod-60 counter (0..9)
//   cnt6_i      live tens digit from the mod-60 counter (0..5)
//   cnt_en_o    count-enable pulse to the counter
//   cnt_clr_o   synchronous clear request to the counter (high in IDLE)
//   disp10_o    ones digit to the display decoder
//   disp6_o     tens digit to the display decoder
//   state_o     FSM state: IDLE=00, RUN=01, LAPF=10, STOP=11
//   lap_led_o   high while the display is frozen on a lap value
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int unsigned DB_MAX = 60000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       btn_ss_i,
  input  logic       btn_lap_i,
  input  logic [3:0] cnt10_i,
  input  logic [2:0] cnt6_i,
  output logic       cnt_en_o,
  output logic       cnt_clr_o,
  output logic [3:0] disp10_o,
  output logic [2:0] disp6_o,
  output logic [1:0] state_o,
  output logic       lap_led_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    LAPF = 2'b10,
    STOP = 2'b11
  } state_e;

  // Last count value of a mismatch run; reaching it completes DB_MAX cycles.
  localparam logic [19:0] DbLast = 20'(DB_MAX - 1);

  // Bit 0 is the start/stop button, bit 1 is the lap button.
  logic [1:0]       btn_raw;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       level_q, level_d;
  logic [1:0]       ev_q, ev_d;
  logic [1:0][19:0] db_cnt_q, db_cnt_d;

  state_e     state_q, state_d;
  logic [6:0] lap_q, lap_d;
  logic       ss_ev, lap_ev;

  assign btn_raw = {btn_lap_i, btn_ss_i};

  // Debounce: count consecutive cycles in which the synchronized input
  // disagrees with the debounced level; any agreement restarts the run.
  // The event is the registered rising edge of the debounced level, so it
  // is high in the first cycle the new level is visible.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    ev_d     = '0;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] != level_q[b]) begin
        if (db_cnt_q[b] == DbLast) begin
          level_d[b] = sync2_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + 20'd1;
        end
      end
      ev_d[b] = level_d[b] & ~level_q[b];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      level_q  <= '0;
      db_cnt_q <= '0;
      ev_q     <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
      ev_q     <= ev_d;
    end
  end

  // Start/stop wins when both events land in the same cycle.
  assign ss_ev  = ev_q[0];
  assign lap_ev = ev_q[1] & ~ev_q[0];

  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    unique case (state_q)
      IDLE: begin
        if (ss_ev) state_d = RUN;
      end
      RUN: begin
        if (ss_ev) begin
          state_d = STOP;
        end else if (lap_ev) begin
          state_d = LAPF;
          lap_d   = {cnt6_i, cnt10_i};
        end
      end
      LAPF: begin
        if (ss_ev)       state_d = STOP;
        else if (lap_ev) state_d = RUN;
      end
      STOP: begin
        if (ss_ev)       state_d = RUN;
        else if (lap_ev) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      lap_q   <= '0;
    end else begin
      state_q <= state_d;
      lap_q   <= lap_d;
    end
  end

  // Outputs decode the registered state only, so a tick coinciding with a
  // RUN->STOP edge is still counted.
  assign cnt_en_o  = tick_i & ((state_q == RUN) | (state_q == LAPF));
  assign cnt_clr_o = (state_q == IDLE);
  assign lap_led_o = (state_q == LAPF);
  assign state_o   = state_q;
  assign disp6_o   = (state_q == LAPF) ? lap_q[6:4] : cnt6_i;
  assign disp10_o  = (state_q == LAPF) ? lap_q[3:0] : cnt10_i;

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DB_MAX, default 60000, SHALL set the debounce stability window in CLK cycles (10 ms at 6 MHz); legal range 2..2^20-1.
REQ-002 CLK  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-003 RESET  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 TICK  input  1  SHALL be the one-cycle 1 Hz enable pulse from the prescaler.
REQ-005 BTN_SS  input  1  SHALL be the raw, asynchronous, active-high start/stop button.
REQ-006 BTN_LAP  input  1  SHALL be the raw, asynchronous, active-high lap/clear button.
REQ-007 CNT10  input  4  SHALL be the live ones digit (0..9) from the mod-60 counter.
REQ-008 CNT6  input  3  SHALL be the live tens digit (0..5) from the mod-60 counter.
REQ-009 CNT_EN  output  1  SHALL be the count-enable pulse to the mod-60 counter.
REQ-010 CNT_CLR  output  1  SHALL be the synchronous clear request to the mod-60 counter, active-high.
REQ-011 DISP10  output  4  SHALL be the ones digit to the display decoder.
REQ-012 DISP6  output  3  SHALL be the tens digit to the display decoder.
REQ-013 STATE  output  2  SHALL expose the FSM state: IDLE=00, RUN=01, LAPF=10, STOP=11.
REQ-014 LAP_LED  output  1  SHALL be high while the display is frozen on a lap value.

Function
REQ-015 Each button SHALL pass through a 2-FF synchronizer before any other logic.
REQ-016 Per button, a debounced level SHALL change only after the synchronized value differs from it for DB_MAX consecutive cycles; any mismatch break SHALL restart the count at 0.
REQ-017 A press event SHALL be a one-cycle pulse, registered, on the 0->1 transition of the debounced level; a held button SHALL yield exactly one event; release SHALL yield none.
REQ-018 IDLE: SS event -> RUN; LAP event ignored.
REQ-019 RUN: SS event -> STOP; LAP event -> LAPF and capture {CNT6,CNT10} into the lap register in the same cycle.
REQ-020 LAPF: LAP event -> RUN; SS event -> STOP.
REQ-021 STOP: SS event -> RUN; LAP event -> IDLE.
REQ-022 SS and LAP events in the same cycle SHALL act on SS only; the LAP event SHALL be discarded.
REQ-023 State SHALL update on the CLK edge following the event pulse; each event SHALL cause at most one transition.
REQ-024 CNT_EN SHALL equal TICK AND (STATE==RUN or STATE==LAPF), combinational from the state register, with zero added latency on TICK.
REQ-025 CNT_CLR SHALL be 1 exactly when STATE==IDLE.
REQ-026 DISP6/DISP10 SHALL show the lap register in LAPF and pass through CNT6/CNT10 combinationally in all other states.
REQ-027 LAP_LED SHALL be 1 exactly when STATE==LAPF.
REQ-028 A TICK in the same cycle as a RUN->STOP transition SHALL still produce CNT_EN, because CNT_EN follows the pre-edge state.
REQ-029 The lap register SHALL hold its value until the next RUN->LAPF capture; the block SHALL NOT alter digit values (wrap 59->00 is the counter's job).

Reset
REQ-030 RESET low SHALL immediately force: state IDLE, lap register 0, synchronizers/debounced levels/debounce counters/event pulses 0.
REQ-031 During reset, outputs SHALL be CNT_EN=0, CNT_CLR=1, STATE=00, LAP_LED=0, and DISP6/DISP10 = CNT6/CNT10.
REQ-032 Reset asserted mid-operation (any state, mid-debounce) SHALL abort pending events; after release, a button already held SHALL produce one event once DB_MAX stable cycles complete.

Verification (bench DB_MAX=4)
REQ-033 Reset release, BTN_SS high for 10 cycles -> one SS event; STATE 00->01; CNT_CLR 1->0; later TICKs appear on CNT_EN.
REQ-034 BTN_SS glitches high for 3 cycles, low for 3 cycles, repeated -> no event; STATE unchanged.
REQ-035 In RUN with CNT6=2, CNT10=7, LAP press -> STATE=10, LAP_LED=1, DISP=2/7 held while inputs advance to 3/1; second LAP -> STATE=01, DISP tracks inputs.
REQ-036 In STOP, TICK pulses -> CNT_EN stays 0; LAP press -> STATE=00, CNT_CLR=1.
REQ-037 Both buttons debounced to the same cycle in RUN -> STATE=11 only; no lap capture; LAP_LED=0.
REQ-038 In LAPF, RESET pulsed low for 1 cycle -> STATE=00, LAP_LED=0, lap register 0, CNT_CLR=1, asynchronously before the next CLK edge.
